mem_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single memory transaction path (mem_transaction_fsm plus mem_spi_controller) between N_REQ crypto-side requesters.
It latches the winning requester's command, issues a one-cycle start, and holds the grant until the transaction FSM reports done.
A watchdog aborts hung transactions.
It sits between the crypto cores and mem_transaction_fsm inside tt_um_mem_toplevel.

---
 rtl/mem_req_arbiter_if.sv | 31 +++
 rtl/mem_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and transaction-side signal bundle for mem_req_arbiter.
// The master modport is the environment (crypto cores and transaction FSM); the slave modport is the arbiter.
interface mem_req_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 24
);
    logic [N_REQ-1:0]        in_req;
    logic [N_REQ-1:0]        in_rw;
    logic [N_REQ*ADDR_W-1:0] in_addr;
    logic [N_REQ-1:0]        out_gnt;
    logic [N_REQ-1:0]        out_done;
    logic [N_REQ-1:0]        out_err;
    logic                    out_txn_start;
    logic                    out_txn_rw;
    logic [ADDR_W-1:0]       out_txn_addr;
    logic                    out_txn_abort;
    logic                    in_txn_done;
    logic                    out_busy;

    modport master (
        output in_req, in_rw, in_addr, in_txn_done,
        input  out_gnt, out_done, out_err, out_txn_start, out_txn_rw,
               out_txn_addr, out_txn_abort, out_busy
    );

    modport slave (
        input  in_req, in_rw, in_addr, in_txn_done,
        output out_gnt, out_done, out_err, out_txn_start, out_txn_rw,
               out_txn_addr, out_txn_abort, out_busy
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that serialises N_REQ requesters onto one memory transaction path,
// latching the winner's command and aborting transactions that exceed TIMEOUT cycles.
module mem_req_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_req_arbiter_if.slave   bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [PTR_W-1:0]   win_reg, win_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic [N_REQ-1:0]   err_reg, err_next;
    logic               start_reg, start_next;
    logic               abort_reg, abort_next;
    logic               busy_reg, busy_next;
    logic               rw_reg, rw_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;

    logic [ADDR_W-1:0]  addr_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign addr_slice[gi] = bus.in_addr[gi*ADDR_W +: ADDR_W];
    end

    // First pending requester at or after ptr, wrapping modulo N_REQ.
    logic               found;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W:0]     sum;
    logic [PTR_W-1:0]   idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            sum = {1'b0, ptr_reg} + (PTR_W+1)'(j);
            if (sum >= (PTR_W+1)'(N_REQ))
                sum = sum - (PTR_W+1)'(N_REQ);
            idx = sum[PTR_W-1:0];
            if (!found && bus.in_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            win_reg   <= '0;
            count_reg <= '0;
            gnt_reg   <= '0;
            done_reg  <= '0;
            err_reg   <= '0;
            start_reg <= 1'b0;
            abort_reg <= 1'b0;
            busy_reg  <= 1'b0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            count_reg <= count_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            start_reg <= start_next;
            abort_reg <= abort_next;
            busy_reg  <= busy_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        count_next = count_reg;
        gnt_next   = gnt_reg;
        done_next  = '0;
        err_next   = '0;
        start_next = 1'b0;
        abort_next = 1'b0;
        busy_next  = busy_reg;
        rw_next    = rw_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next     = START;
                    win_next       = pick;
                    gnt_next       = '0;
                    gnt_next[pick] = 1'b1;
                    addr_next      = addr_slice[pick];
                    rw_next        = bus.in_rw[pick];
                    start_next     = 1'b1;
                    busy_next      = 1'b1;
                end
            end
            START: begin
                state_next = WAIT;
                count_next = '0;
            end
            WAIT: begin
                // Done wins over a coincident timeout.
                if (bus.in_txn_done || count_reg == CNT_W'(TIMEOUT - 1)) begin
                    if (bus.in_txn_done) begin
                        done_next[win_reg] = 1'b1;
                    end else begin
                        err_next[win_reg] = 1'b1;
                        abort_next        = 1'b1;
                    end
                    state_next = IDLE;
                    gnt_next   = '0;
                    busy_next  = 1'b0;
                    ptr_next   = (win_reg == PTR_W'(N_REQ - 1)) ? '0 : win_reg + 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.out_gnt       = gnt_reg;
    assign bus.out_done      = done_reg;
    assign bus.out_err       = err_reg;
    assign bus.out_txn_start = start_reg;
    assign bus.out_txn_abort = abort_reg;
    assign bus.out_txn_rw    = rw_reg;
    assign bus.out_txn_addr  = addr_reg;
    assign bus.out_busy      = busy_reg;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level reference model.
module tb_mem_req_arbiter;
    localparam int N  = 2;
    localparam int AW = 24;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

    mem_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the path, whether the start cycle is in progress,
    // how many cycles the owner has spent waiting, and whose turn comes first.
    int              m_owner;
    bit              m_starting;
    int              m_waited;
    int              m_ptr;
    logic [N-1:0]    e_gnt, e_done, e_err;
    logic            e_start, e_abort, e_rw, e_busy;
    logic [AW-1:0]   e_addr;

    task automatic model_reset();
        m_owner = -1; m_starting = 0; m_waited = 0; m_ptr = 0;
        e_gnt = '0; e_done = '0; e_err = '0;
        e_start = 0; e_abort = 0; e_rw = 0; e_busy = 0; e_addr = '0;
    endtask

    task automatic model_close(input bit ok);
        if (ok) e_done[m_owner] = 1'b1;
        else begin
            e_err[m_owner] = 1'b1;
            e_abort = 1'b1;
        end
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        e_gnt   = '0;
        e_busy  = 1'b0;
    endtask

    task automatic model_step();
        e_done = '0; e_err = '0; e_start = 0; e_abort = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && bus.in_req[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                e_gnt = '0;
                e_gnt[m_owner] = 1'b1;
                e_start = 1'b1;
                e_busy  = 1'b1;
                e_addr  = bus.in_addr[m_owner*AW +: AW];
                e_rw    = bus.in_rw[m_owner];
                m_starting = 1;
            end
        end else if (m_starting) begin
            m_starting = 0;
            m_waited   = 0;
        end else if (bus.in_txn_done) begin
            model_close(1);
        end else if (m_waited == TO - 1) begin
            model_close(0);
        end else begin
            m_waited++;
        end
    endtask

    task automatic compare_all();
        check_val("gnt",   bus.out_gnt,       e_gnt);
        check_val("done",  bus.out_done,      e_done);
        check_val("err",   bus.out_err,       e_err);
        check_val("start", bus.out_txn_start, e_start);
        check_val("abort", bus.out_txn_abort, e_abort);
        check_val("rw",    bus.out_txn_rw,    e_rw);
        check_val("addr",  bus.out_txn_addr,  e_addr);
        check_val("busy",  bus.out_busy,      e_busy);
        check_val("gnt_onehot", ($countones(bus.out_gnt) <= 1), 1);
        check_val("done_err_excl", |(bus.out_done & bus.out_err), 0);
    endtask

    // Called with inputs already driven at the falling edge; returns at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.in_req = '0; bus.in_rw = '0; bus.in_addr = '0; bus.in_txn_done = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Single request
        bus.in_req = 2'b01; bus.in_rw[0] = 1'b1; bus.in_addr[0 +: AW] = 24'h00A5C3;
        cycle();
        check_val("t1_gnt",   bus.out_gnt, 2'b01);
        check_val("t1_start", bus.out_txn_start, 1);
        check_val("t1_addr",  bus.out_txn_addr, 24'h00A5C3);
        check_val("t1_rw",    bus.out_txn_rw, 1);
        run(5);
        bus.in_txn_done = 1'b1;
        cycle();
        check_val("t1_done", bus.out_done, 2'b01);
        check_val("t1_idle", bus.out_gnt, 2'b00);
        bus.in_txn_done = 1'b0; bus.in_req = '0;

        // Contention: ptr now points at requester 1
        bus.in_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] want;
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            cycle();
            check_val("fair_gnt", bus.out_gnt, want);
            run(2);
            bus.in_txn_done = 1'b1;
            cycle();
            check_val("fair_gap", bus.out_gnt, 2'b00);
            bus.in_txn_done = 1'b0;
        end

        // Timeout on requester 1
        bus.in_req = 2'b10;
        cycle();
        check_val("to_gnt", bus.out_gnt, 2'b10);
        cycle();
        for (int i = 0; i < TO - 1; i++) begin
            cycle();
            check_val("to_early_err", bus.out_err, 2'b00);
        end
        cycle();
        check_val("to_err",   bus.out_err, 2'b10);
        check_val("to_abort", bus.out_txn_abort, 1);
        bus.in_req = 2'b11;
        cycle();
        check_val("to_next_gnt", bus.out_gnt, 2'b01);

        // Done on the final WAIT cycle
        cycle();
        run(TO - 1);
        bus.in_txn_done = 1'b1;
        cycle();
        check_val("tie_done",  bus.out_done, 2'b01);
        check_val("tie_err",   bus.out_err, 2'b00);
        check_val("tie_abort", bus.out_txn_abort, 0);
        bus.in_txn_done = 1'b0; bus.in_req = '0;

        // Mid-transaction input changes, then a stray done in IDLE
        bus.in_req = 2'b10; bus.in_rw[1] = 1'b0; bus.in_addr[AW +: AW] = 24'h123456;
        cycle();
        bus.in_req = 2'b00; bus.in_rw[1] = 1'b1; bus.in_addr[AW +: AW] = 24'hFFFFFF;
        run(3);
        check_val("mid_addr", bus.out_txn_addr, 24'h123456);
        check_val("mid_rw",   bus.out_txn_rw, 0);
        bus.in_txn_done = 1'b1;
        cycle();
        check_val("mid_done", bus.out_done, 2'b10);
        cycle();
        check_val("stray_done", bus.out_done, 2'b00);
        check_val("stray_busy", bus.out_busy, 0);
        bus.in_txn_done = 1'b0;

        // Asynchronous reset while in WAIT
        bus.in_req = 2'b10;
        run(3);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        check_val("rst_gnt", bus.out_gnt, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_req = 2'b11;
        cycle();
        check_val("rst_ptr_gnt", bus.out_gnt, 2'b01);
        bus.in_req = '0;
        bus.in_txn_done = 1'b1;
        run(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) bus.in_req[b] = ~bus.in_req[b];
            bus.in_rw       = N'($urandom);
            bus.in_addr     = {$urandom, $urandom};
            bus.in_txn_done = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
